wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the register file; it drives the regfile's single write port (data_in, write_enable, write_addr).
- Merges two result sources into that port:
  - ALU: single-cycle results, high priority.
  - Memory/long-latency unit: buffered through a small FIFO.
- Registers the selected write one cycle ahead of the regfile, suppresses x0 writes, and bounds FIFO starvation with a counter.

---
 rtl/wb_arbiter_pkg.sv | 12 +
 rtl/wb_arbiter_if.sv | 28 ++
 rtl/wb_fifo.sv | 56 +++++
 rtl/wb_arbiter.sv | 104 ++++++++++
 tb/tb_wb_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter.
//   XLEN, REG_ADDR_W : datapath and register-address widths.
//   wb_entry_t       : one pending register write {rd, data}.
package wb_arbiter_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: ALU and memory result handshakes plus the regfile write port.
//   master : result producers / regfile side (drives valid/rd/data, sees ready and rf_*).
//   slave  : the arbiter (drives ready and rf_*).
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [XLEN-1:0]       mem_data;
    logic                  rf_write_enable;
    logic [REG_ADDR_W-1:0] rf_write_addr;
    logic [XLEN-1:0]       rf_data_in;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready, rf_write_enable, rf_write_addr, rf_data_in
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready, rf_write_enable, rf_write_addr, rf_data_in
    );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_entry_t used to buffer memory results.
//   clk, rst     : clock, async active-high reset (empties the FIFO).
//   push_i/data  : write an entry (caller guarantees !full_o).
//   pop_i        : drop the head (caller guarantees !empty_o); head on pop_data_o.
//   count_o      : occupancy 0..DEPTH; full_o / empty_o derived from it.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  wb_entry_t                  push_data_i,
    input  logic                       pop_i,
    output wb_entry_t                  pop_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);

    wb_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_i);
        rd_ptr_d = rd_ptr_q + AW'(pop_i);
        count_d  = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results (priority) and buffered
// memory results into the regfile's single write port, one cycle ahead of it.
//   clk, rst   : clock, async active-high reset (drops buffered/in-flight results).
//   bus        : wb_arbiter_if.slave -- ALU/mem handshakes and rf_* write port.
//   fifo_count : current memory-result FIFO occupancy.
// Optional macro WB_FWD_EN adds a combinational read bypass:
//   rd_addr1/2, rf_rdata1/2 in; fwd_rdata1/2 out.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    wb_arbiter_if.slave                   bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef WB_FWD_EN
    ,
    input  logic [REG_ADDR_W-1:0]         rd_addr1,
    input  logic [REG_ADDR_W-1:0]         rd_addr2,
    input  logic [XLEN-1:0]               rf_rdata1,
    input  logic [XLEN-1:0]               rf_rdata2,
    output logic [XLEN-1:0]               fwd_rdata1,
    output logic [XLEN-1:0]               fwd_rdata2
`endif
);
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    wb_entry_t             fifo_head, alu_entry, sel_entry;
    logic                  fifo_full, fifo_empty, fifo_push;
    logic                  force_fifo, sel_alu, sel_fifo;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       data_q, data_d;

    assign alu_entry = '{rd: bus.alu_rd, data: bus.alu_data};
    // Full blocks the push even if the head pops this cycle.
    assign fifo_push = bus.mem_valid && !fifo_full;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i ('{rd: bus.mem_rd, data: bus.mem_data}),
        .pop_i       (sel_fifo),
        .pop_data_o  (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // After STARVE_LIMIT consecutive ALU wins over a waiting FIFO, the FIFO
    // head is forced through and the ALU is back-pressured for that cycle.
    assign force_fifo    = (starve_q == STARVE_MAX) && !fifo_empty;
    assign sel_alu       = !force_fifo && bus.alu_valid;
    assign sel_fifo      = !fifo_empty && !sel_alu;
    assign sel_entry     = sel_alu ? alu_entry : fifo_head;
    assign bus.alu_ready = !force_fifo;
    assign bus.mem_ready = !fifo_full;

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || sel_fifo)
            starve_d = '0;
        else if (sel_alu && starve_q != STARVE_MAX)
            starve_d = starve_q + SW'(1);

        // x0 results are consumed but never written; addr/data still track.
        we_d   = (sel_alu || sel_fifo) && (sel_entry.rd != '0);
        addr_d = addr_q;
        data_d = data_q;
        if (sel_alu || sel_fifo) begin
            addr_d = sel_entry.rd;
            data_d = sel_entry.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            starve_q <= starve_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign bus.rf_write_enable = we_q;
    assign bus.rf_write_addr   = addr_q;
    assign bus.rf_data_in      = data_q;

`ifdef WB_FWD_EN
    // Covers the cycle where the regfile has not yet committed our write.
    assign fwd_rdata1 = (we_q && addr_q == rd_addr1 && rd_addr1 != '0) ? data_q : rf_rdata1;
    assign fwd_rdata2 = (we_q && addr_q == rd_addr2 && rd_addr2 != '0) ? data_q : rf_rdata2;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter. Expected regfile writes are
// queued in the order the arbitration rules dictate and checked as they appear.
module tb_wb_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] fifo_count;
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [36:0] exp_q [$];
    logic [31:0] tb_rf [32];

    wb_arbiter_if bus ();

`ifdef WB_FWD_EN
    logic [4:0]  rd_addr1, rd_addr2;
    logic [31:0] rf_rdata1, rf_rdata2, fwd_rdata1, fwd_rdata2;
`endif

    wb_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_count (fifo_count)
`ifdef WB_FWD_EN
        ,
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .fwd_rdata1 (fwd_rdata1),
        .fwd_rdata2 (fwd_rdata2)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Regfile stand-in: commits on the edge after rf_* become valid.
    always @(posedge clk) begin
        if (bus.rf_write_enable) tb_rf[bus.rf_write_addr] <= bus.rf_data_in;
    end

    // Scoreboard: every write that reaches the regfile must be the next expected one.
    always @(negedge clk) begin
        if (!rst && bus.rf_write_enable) begin
            if (exp_q.size() == 0) begin
                check("stray_write", 64'(bus.rf_write_enable), 64'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(bus.rf_write_addr), 64'(e[36:32]));
                check("wr_data", 64'(bus.rf_data_in), 64'(e[31:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] ar_pat, mr_pat;
        int         cnt_pat [9];
        int         alu_idx, mem_idx, pop_idx;

        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
`ifdef WB_FWD_EN
        rd_addr1 = 0; rd_addr2 = 0; rf_rdata1 = 0; rf_rdata2 = 0;
`endif
        // Reset values
        #1 rst = 1;
        #1;
        check("rst_we",    64'(bus.rf_write_enable), 64'd0);
        check("rst_addr",  64'(bus.rf_write_addr), 64'd0);
        check("rst_data",  64'(bus.rf_data_in), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        step();
        rst = 0;
        check("rst_mem_ready", 64'(bus.mem_ready), 64'd1);
        check("rst_alu_ready", 64'(bus.alu_ready), 64'd1);

        // ALU only
        bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        @(negedge clk);
        check("alu_ready", 64'(bus.alu_ready), 64'd1);
        step();
        bus.alu_valid = 0;
        check("alu_we_next", 64'(bus.rf_write_enable), 64'd1);
        step();
        check("rf_read_r5", 64'(tb_rf[5]), 64'hDEADBEEF);

        // Memory burst, ALU idle: drains one per cycle
        for (int i = 1; i <= 5; i++) begin
            bus.mem_valid = 1; bus.mem_rd = 5'(i); bus.mem_data = 32'h100 + 32'(i);
            exp_q.push_back({5'(i), 32'h100 + 32'(i)});
            @(negedge clk);
            check("burst_mem_ready", 64'(bus.mem_ready), 64'd1);
            check("burst_count", 64'(fifo_count), (i == 1) ? 64'd0 : 64'd1);
            step();
        end
        bus.mem_valid = 0;
        repeat (3) step();
        check("burst_drained", 64'(fifo_count), 64'd0);

        // Starvation: rd=7 waits behind 3 ALU wins, then is forced through
        alu_idx = 0;
        for (int i = 0; i < 6; i++) begin
            bus.alu_valid = 1; bus.alu_rd = 5'(10 + alu_idx); bus.alu_data = 32'hA000 + 32'(alu_idx);
            bus.mem_valid = (i == 0); bus.mem_rd = 7; bus.mem_data = 32'h7777;
            @(negedge clk);
            check("starve_alu_ready", 64'(bus.alu_ready), (i == 4) ? 64'd0 : 64'd1);
            if (i == 4) begin
                exp_q.push_back({5'd7, 32'h7777});
            end else begin
                exp_q.push_back({5'(10 + alu_idx), 32'hA000 + 32'(alu_idx)});
                alu_idx++;
            end
            step();
        end
        bus.alu_valid = 0; bus.mem_valid = 0;
        repeat (2) step();
        check("starve_drained", 64'(fifo_count), 64'd0);

        // Full FIFO under ALU saturation: bit i = cycle i
        ar_pat  = 9'b011101111;
        mr_pat  = 9'b000101111;
        cnt_pat = '{0, 1, 2, 3, 4, 3, 4, 4, 4};
        alu_idx = 0; mem_idx = 0; pop_idx = 0;
        for (int i = 0; i < 9; i++) begin
            bus.alu_valid = 1; bus.alu_rd = 5'(16 + alu_idx); bus.alu_data = 32'hB000 + 32'(alu_idx);
            bus.mem_valid = 1; bus.mem_rd = 5'(20 + mem_idx); bus.mem_data = 32'hC000 + 32'(mem_idx);
            @(negedge clk);
            check("full_alu_ready", 64'(bus.alu_ready), 64'(ar_pat[i]));
            check("full_mem_ready", 64'(bus.mem_ready), 64'(mr_pat[i]));
            check("full_count", 64'(fifo_count), 64'(cnt_pat[i]));
            if (ar_pat[i]) begin
                exp_q.push_back({5'(16 + alu_idx), 32'hB000 + 32'(alu_idx)});
                alu_idx++;
            end else begin
                exp_q.push_back({5'(20 + pop_idx), 32'hC000 + 32'(pop_idx)});
                pop_idx++;
            end
            if (mr_pat[i]) mem_idx++;
            step();
        end
        bus.alu_valid = 0; bus.mem_valid = 0;
        while (pop_idx < mem_idx) begin
            exp_q.push_back({5'(20 + pop_idx), 32'hC000 + 32'(pop_idx)});
            pop_idx++;
        end
        repeat (4) step();
        check("full_drained", 64'(fifo_count), 64'd0);
        check("full_sb_empty", 64'(exp_q.size()), 64'd0);

        // x0 write is consumed but not written
        bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'h1;
        @(negedge clk);
        check("x0_alu_ready", 64'(bus.alu_ready), 64'd1);
        step();
        bus.alu_valid = 0;
        check("x0_we", 64'(bus.rf_write_enable), 64'd0);
        check("x0_addr", 64'(bus.rf_write_addr), 64'd0);
        check("x0_data", 64'(bus.rf_data_in), 64'd1);
        step();

`ifdef WB_FWD_EN
        // Bypass while the write to r9 is pending
        bus.alu_valid = 1; bus.alu_rd = 9; bus.alu_data = 32'hA5;
        exp_q.push_back({5'd9, 32'hA5});
        step();
        bus.alu_valid = 0;
        rd_addr1 = 9; rf_rdata1 = 32'h1111; rd_addr2 = 0; rf_rdata2 = 32'h2222;
        #1;
        check("fwd1_hit", 64'(fwd_rdata1), 64'hA5);
        check("fwd2_x0_raw", 64'(fwd_rdata2), 64'h2222);
        rd_addr1 = 0;
        #1;
        check("fwd1_x0_raw", 64'(fwd_rdata1), 64'h1111);
        rd_addr1 = 3;
        #1;
        check("fwd1_miss", 64'(fwd_rdata1), 64'h1111);
        step();
`endif

        // Reset mid-stream with three buffered mem results
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1; bus.alu_rd = 5'(24 + i); bus.alu_data = 32'hD000 + 32'(i);
            bus.mem_valid = 1; bus.mem_rd = 5'(28 + i); bus.mem_data = 32'hE000 + 32'(i);
            exp_q.push_back({5'(24 + i), 32'hD000 + 32'(i)});
            step();
        end
        bus.alu_valid = 0; bus.mem_valid = 0;
        check("mid_count_pre", 64'(fifo_count), 64'd3);
        @(negedge clk);
        #1 rst = 1;
        #1;
        check("mid_rst_we", 64'(bus.rf_write_enable), 64'd0);
        check("mid_rst_count", 64'(fifo_count), 64'd0);
        check("mid_rst_addr", 64'(bus.rf_write_addr), 64'd0);
        step();
        step();
        rst = 0;
        repeat (3) begin
            check("post_rst_we", 64'(bus.rf_write_enable), 64'd0);
            step();
        end
        check("post_rst_count", 64'(fifo_count), 64'd0);
        check("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
